uart_tx_buf: RTL and testbench

//  Byte buffer and launcher directly upstream of the UART transmitter.
//  - Accepts bytes from the system side into a synchronous FIFO.
//  - Feeds the transmitter one byte at a time: pulses tx_start with tx_data, then waits for tx_done_tick.
//  - Decouples bursty producers from the slow serial line.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_tx_buf_if.sv | 28 ++
 rtl/uart_fifo.sv | 60 ++++++
 rtl/uart_tx_buf.sv | 88 ++++++++
 tb/tb_uart_tx_buf.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-buffer FSM state encoding and the default byte width.
package uart_pkg;

    typedef enum logic {IDLE, WAIT} tx_buf_state_t;

    localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_buf_if.sv
// System-side and transmitter-side signals of uart_tx_buf, bundled with directional modports.
interface uart_tx_buf_if import uart_pkg::*; #(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              ovf_clr;
    logic              tx_done_tick;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic [15:0]       sent_cnt;

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_done_tick,
        output full, empty, level, overflow, tx_start, tx_data, busy, sent_cnt
    );

    modport master (
        output wr_en, wr_data, ovf_clr, tx_done_tick,
        input  full, empty, level, overflow, tx_start, tx_data, busy, sent_cnt
    );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO, 2**ADDR_W entries, show-ahead read port; shared by the UART tx and rx paths.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              do_wr, do_rd;

    // Full/empty come from the registered level, so a same-cycle pop never frees room for a write.
    assign full   = (level_q == (ADDR_W + 1)'(DEPTH));
    assign empty  = (level_q == '0);
    assign level  = level_q;
    assign r_data = mem_q[rp_q];
    assign do_wr  = wr & ~full;
    assign do_rd  = rd & ~empty;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        if (do_wr) wp_d = wp_q + ADDR_W'(1);
        if (do_rd) rp_d = rp_q + ADDR_W'(1);
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wp_q] <= w_data;
    end
endmodule

// File: rtl/uart_tx_buf.sv
// Byte buffer ahead of the UART transmitter: FIFO, launch FSM, sticky overflow flag.
// Define UART_TX_BUF_CNT_EN to build the 16-bit sent-byte counter; otherwise sent_cnt reads 0.
module uart_tx_buf import uart_pkg::*; #(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_buf_if.slave  bus
);
    tx_buf_state_t     state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;

    uart_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr     (bus.wr_en),
        .rd     (pop),
        .w_data (bus.wr_data),
        .r_data (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (bus.level)
    );

    assign pop = (state_q == IDLE) & ~fifo_empty;

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: if (pop) begin
                tx_start_d = 1'b1;
                tx_data_d  = fifo_rdata;
                state_d    = WAIT;
            end
            WAIT: if (bus.tx_done_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Clear wins over a same-cycle dropped write.
        ovf_d = bus.ovf_clr ? 1'b0 : ((bus.wr_en & fifo_full) ? 1'b1 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef UART_TX_BUF_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == WAIT) && bus.tx_done_tick) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.sent_cnt = cnt_q;
`else
    assign bus.sent_cnt = 16'h0;
`endif

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = ovf_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state_q != IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: vector table for single-cycle behaviour, sequences for burst,
// overflow, pointer wrap, mid-frame reset and the optional sent-byte counter.
module tb_uart_tx_buf;
    logic clk = 1'b0;
    logic rst;
    logic tx_done_man  = 1'b0;
    logic tx_done_auto = 1'b0;
    logic auto_en      = 1'b0;
    int   auto_dly     = 3;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_start = 1'b0;
    logic [7:0] launched[$];
    logic [7:0] expq[$];

    always #5 clk = ~clk;

    uart_tx_buf_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    uart_tx_buf #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_done_tick = tx_done_man | tx_done_auto;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; returns #1 after the edge that sampled them.
    task automatic step(input logic w, input logic [7:0] d, input logic clr,
                        input logic done, input logic r);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.ovf_clr = clr;
        tx_done_man = done;
        rst         = r;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        tx_done_man = 1'b0;
        rst         = 1'b0;
    endtask

    // Launch monitor: records every byte and flags a tx_start longer than one cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_start) begin
                launched.push_back(bus.tx_data);
                chk("tx_start_single_cycle", {31'd0, prev_start}, 32'd0);
            end
            prev_start = bus.tx_start;
        end
    end

    // Transmitter model: answers each launch with tx_done_tick after auto_dly cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_en && bus.tx_start) begin
                repeat (auto_dly) @(posedge clk);
                #1 tx_done_auto = 1'b1;
                @(posedge clk);
                #1 tx_done_auto = 1'b0;
            end
        end
    end

    typedef struct {
        logic       rst, wr, clr, done;
        logic [7:0] d;
        logic       e_start;
        logic [7:0] e_data;
        logic [4:0] e_level;
        logic       e_empty, e_full, e_ovf, e_busy;
    } vec_t;

    vec_t vt[13];

    task automatic drain(input int exp_n, input int bound);
        int c;
        c = 0;
        while (c < bound && !(launched.size() == exp_n && !bus.busy && !auto_busy())) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            c++;
        end
        chk("drain_done_in_budget", {31'd0, (c < bound)}, 32'd1);
    endtask

    function automatic logic auto_busy();
        return tx_done_auto;
    endfunction

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        //          rst  wr   clr  done d      start data   lvl  emp  full ovf  busy
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00, 5'd0,1'b1,1'b0,1'b0,1'b0};
        vt[1]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00, 5'd0,1'b1,1'b0,1'b0,1'b0};
        vt[2]  = '{1'b0,1'b1,1'b0,1'b0,8'hA5, 1'b0,8'h00, 5'd1,1'b0,1'b0,1'b0,1'b1};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,8'hA5, 5'd0,1'b1,1'b0,1'b0,1'b1};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,8'hA5, 5'd0,1'b1,1'b0,1'b0,1'b1};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,8'hA5, 5'd0,1'b1,1'b0,1'b0,1'b0};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,8'hA5, 5'd0,1'b1,1'b0,1'b0,1'b0};
        vt[7]  = '{1'b0,1'b1,1'b0,1'b0,8'h3C, 1'b0,8'hA5, 5'd1,1'b0,1'b0,1'b0,1'b1};
        vt[8]  = '{1'b0,1'b1,1'b0,1'b0,8'h7E, 1'b1,8'h3C, 5'd1,1'b0,1'b0,1'b0,1'b1};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,8'h3C, 5'd1,1'b0,1'b0,1'b0,1'b1};
        vt[10] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,8'h7E, 5'd0,1'b1,1'b0,1'b0,1'b1};
        vt[11] = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h7E, 5'd0,1'b1,1'b0,1'b0,1'b1};
        vt[12] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,8'h7E, 5'd0,1'b1,1'b0,1'b0,1'b0};

        foreach (vt[i]) begin
            step(vt[i].wr, vt[i].d, vt[i].clr, vt[i].done, vt[i].rst);
            chk($sformatf("v%0d_tx_start", i), {31'd0, bus.tx_start}, {31'd0, vt[i].e_start});
            chk($sformatf("v%0d_tx_data", i),  {24'd0, bus.tx_data},  {24'd0, vt[i].e_data});
            chk($sformatf("v%0d_level", i),    {27'd0, bus.level},    {27'd0, vt[i].e_level});
            chk($sformatf("v%0d_empty", i),    {31'd0, bus.empty},    {31'd0, vt[i].e_empty});
            chk($sformatf("v%0d_full", i),     {31'd0, bus.full},     {31'd0, vt[i].e_full});
            chk($sformatf("v%0d_overflow", i), {31'd0, bus.overflow}, {31'd0, vt[i].e_ovf});
            chk($sformatf("v%0d_busy", i),     {31'd0, bus.busy},     {31'd0, vt[i].e_busy});
        end

        // Burst and overflow: 0x01 launches at once and stalls in WAIT, so 0x02..0x11 fill all 16 slots.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        launched.delete();
        for (int i = 1; i <= 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("burst_full", {31'd0, bus.full}, 32'd1);
        chk("burst_level", {27'd0, bus.level}, 32'd16);
        chk("burst_one_launch", launched.size(), 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
        chk("ovf_level_unchanged", {27'd0, bus.level}, 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("ovf_clr_priority", {31'd0, bus.overflow}, 32'd0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("ovf_set_again", {31'd0, bus.overflow}, 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("ovf_clr", {31'd0, bus.overflow}, 32'd0);
        auto_en  = 1'b1;
        auto_dly = 2;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drain(17, 400);
        chk("burst_launch_count", launched.size(), 32'd17);
        for (int i = 0; i < 17 && i < launched.size(); i++)
            chk($sformatf("burst_order_%0d", i), {24'd0, launched[i]}, 32'(i + 1));
        chk("burst_empty", {31'd0, bus.empty}, 32'd1);

        // Pointer wrap: 40 bytes with random gaps, writer never exceeds capacity.
        auto_dly = 4;
        launched.delete();
        expq.delete();
        begin
            int written = 0;
            int c = 0;
            while (written < 40 && c < 3000) begin
                logic w;
                logic [7:0] d;
                w = ($urandom_range(0, 2) != 0) && !bus.full;
                d = 8'(written * 7 + 3);
                if (w) begin
                    expq.push_back(d);
                    written++;
                end
                step(w, d, 1'b0, 1'b0, 1'b0);
                chk("wrap_level_max", {31'd0, (bus.level <= 5'd16)}, 32'd1);
                c++;
            end
            chk("wrap_all_written", written, 32'd40);
        end
        drain(40, 1000);
        chk("wrap_count", launched.size(), 32'd40);
        for (int i = 0; i < 40 && i < launched.size(); i++)
            chk($sformatf("wrap_byte_%0d", i), {24'd0, launched[i]}, {24'd0, expq[i]});
        chk("wrap_no_overflow", {31'd0, bus.overflow}, 32'd0);

        // Mid-frame reset with bytes still queued.
        auto_en = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", {27'd0, bus.level}, 32'd2);
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        launched.delete();
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("rst_level", {27'd0, bus.level}, 32'd0);
        chk("rst_busy_idle", {31'd0, bus.busy}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("stray_done_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("stray_done_no_launch", launched.size(), 32'd0);
        chk("rst_sent_cnt", {16'd0, bus.sent_cnt}, 32'd0);

        // Sent-byte counter over five completed frames.
        auto_en  = 1'b1;
        auto_dly = 2;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        drain(5, 300);
`ifdef UART_TX_BUF_CNT_EN
        chk("sent_cnt", {16'd0, bus.sent_cnt}, 32'd5);
`else
        chk("sent_cnt_tied_off", {16'd0, bus.sent_cnt}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
